// File: rtl/csel_sub_64bit_pipe.sv
// Four-stage pipelined 64-bit subtractor (op1 - op2 - bin) built from 4-bit
// carry-select blocks. Each stage resolves 16 bits; the inter-stage carry and the
// unconsumed operand slices travel with the op through the pipeline registers.
module csel_sub_64bit_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        ovf
);

  // 16-bit slice from four 4-bit carry-select blocks; returns {carry_out, sum}.
  function automatic logic [16:0] csel16(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        cin);
    logic        c;
    logic [15:0] s;
    logic [4:0]  r0;
    logic [4:0]  r1;
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
      r1 = r0 + 5'd1;
      s[4*i +: 4] = c ? r1[3:0] : r0[3:0];
      c = c ? r1[4] : r0[4];
    end
    return {c, s};
  endfunction

  // Stage 0 registers
  logic        v0_q;
  logic [15:0] d0_q;
  logic        c0_q;
  logic [47:0] a0_q, b0_q;
  logic        sa0_q, sb0_q;
  // Stage 1 registers
  logic        v1_q;
  logic [31:0] d1_q;
  logic        c1_q;
  logic [31:0] a1_q, b1_q;
  logic        sa1_q, sb1_q;
  // Stage 2 registers
  logic        v2_q;
  logic [47:0] d2_q;
  logic        c2_q;
  logic [15:0] a2_q, b2_q;
  logic        sa2_q, sb2_q;
  // Stage 3 registers (outputs)
  logic        out_valid_q;
  logic [63:0] diff_q;
  logic        bout_q, ovf_q;

  logic        adv, acc;
  logic [16:0] s0_d, s1_d, s2_d, s3_d;
  logic [63:0] diff_d;
  logic        bout_d, ovf_d;

  // Global advance, handshake and per-stage slice arithmetic.
  always_comb begin
    adv      = ~out_valid_q | out_ready;
    in_ready = adv & reset;
    acc      = in_valid & in_ready;
    s0_d     = csel16(op1[15:0], ~op2[15:0], ~bin);
    s1_d     = csel16(a0_q[15:0], b0_q[15:0], c0_q);
    s2_d     = csel16(a1_q[15:0], b1_q[15:0], c1_q);
    s3_d     = csel16(a2_q, b2_q, c2_q);
    diff_d   = {s3_d[15:0], d2_q};
    bout_d   = ~s3_d[16];
    ovf_d    = (sa2_q != sb2_q) & (s3_d[15] != sa2_q);
  end

  // Pipeline shift; data registers load only behind a valid op so bubbles
  // and idle inputs never reach the outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      v0_q        <= acc;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (acc) begin
        d0_q  <= s0_d[15:0];
        c0_q  <= s0_d[16];
        a0_q  <= op1[63:16];
        b0_q  <= ~op2[63:16];
        sa0_q <= op1[63];
        sb0_q <= op2[63];
      end
      if (v0_q) begin
        d1_q  <= {s1_d[15:0], d0_q};
        c1_q  <= s1_d[16];
        a1_q  <= a0_q[47:16];
        b1_q  <= b0_q[47:16];
        sa1_q <= sa0_q;
        sb1_q <= sb0_q;
      end
      if (v1_q) begin
        d2_q  <= {s2_d[15:0], d1_q};
        c2_q  <= s2_d[16];
        a2_q  <= a1_q[31:16];
        b2_q  <= b1_q[31:16];
        sa2_q <= sa1_q;
        sb2_q <= sb1_q;
      end
      if (v2_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_sub_64bit_pipe.sv
// Self-checking bench for csel_sub_64bit_pipe: directed vector table, backpressure
// sequence, randomized traffic against a plain-arithmetic model, and resets.
module tb_csel_sub_64bit_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1, op2;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout, ovf;

  csel_sub_64bit_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    int          due;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  int   mode = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: wide unsigned and signed arithmetic straight from the definition.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic c,
                       output logic [63:0] d, output logic bo, output logic ov);
    logic [64:0]        u;
    logic signed [65:0] s;
    u  = {1'b0, a} - {1'b0, b} - {64'd0, c};
    s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, c});
    d  = u[63:0];
    bo = u[64];
    ov = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
  endtask

  // out_ready driver: 0 = always ready, 1 = fixed pattern, 2 = random.
  initial begin
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int bp_idx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (mode == 1) begin
        if (out_valid || bp_idx > 0) begin
          out_ready = (bp_idx < 7) ? pat[bp_idx] : 1'b1;
          bp_idx++;
        end else out_ready = 1'b1;
      end else begin
        bp_idx = 0;
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: handshake rule, stall stability, in-order result checking.
  logic        prev_stall = 1'b0, prev_rst = 1'b0;
  logic [63:0] prev_diff;
  logic [2:0]  prev_flags;
  always @(negedge clock) begin
    if (mon_en) begin
      check("in_ready_rule", {63'd0, in_ready},
            {63'd0, reset && (!out_valid || out_ready)});
      if (prev_stall && prev_rst) begin
        check("stall_hold_diff", diff, prev_diff);
        check("stall_hold_flags", {61'd0, out_valid, bout, ovf}, {61'd0, prev_flags});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("diff", diff, e.diff);
          check("bout_ovf", {62'd0, bout, ovf}, {62'd0, e.bout, e.ovf});
          if (e.lat) check("latency", 64'(cyc), 64'(e.due));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_rst   = reset;
      prev_diff  = diff;
      prev_flags = {out_valid, bout, ovf};
    end
  end

  task automatic garbage();
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    bin = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [63:0] ed, input logic eb, input logic eo,
                       input bit lat, input bit track);
    bit acc = 0;
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    bin = c;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1;
        if (track) exp_q.push_back('{ed, eb, eo, cyc + 4, lat});
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    garbage();
    if (!acc) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_model(input logic [63:0] a, input logic [63:0] b, input logic c,
                             input bit lat);
    logic [63:0] d;
    logic        bo, ov;
    model(a, b, c, d, bo, ov);
    issue(a, b, c, d, bo, ov, lat, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clock);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{64'h5, 64'h3, 1'b0, 64'h2, 1'b0, 1'b0};
    vt[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[2] = '{64'h1_0000, 64'h0, 1'b1, 64'hFFFF, 1'b0, 1'b0};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[6] = '{64'h1234, 64'h1234, 1'b0, 64'h0, 1'b0, 1'b0};

    // Reset held 2 cycles with in_valid high.
    reset = 1'b0;
    in_valid = 1'b1;
    garbage();
    for (int r = 0; r < 2; r++) begin
      @(posedge clock);
      #1;
      mon_en = 1;
      @(negedge clock);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_diff", diff, 64'd0);
      check("rst_bout_ovf", {62'd0, bout, ovf}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    idle(6);

    // Directed table, back to back at full rate; each must emerge at +4.
    for (int i = 0; i < 7; i++)
      issue(vt[i].a, vt[i].b, vt[i].c, vt[i].diff, vt[i].bout, vt[i].ovf, 1'b1, 1'b1);
    drain();
    idle(2);

    // Backpressure: i - 2i for i = 1..6 under the fixed out_ready pattern.
    mode = 1;
    for (int i = 1; i <= 6; i++) issue_model(64'(i), 64'(2 * i), 1'b0, 1'b0);
    drain();
    mode = 0;
    idle(3);

    // Randomized traffic with random gaps and random backpressure.
    mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a[63:16] = '0;
      issue_model(a, b, 1'($urandom_range(0, 1)), 1'b0);
      idle($urandom_range(0, 2));
    end
    mode = 0;
    drain();
    idle(2);

    // Reset mid-flight discards in-flight ops; a fresh op follows at +4.
    for (int i = 0; i < 3; i++) issue(64'(10 + i), 64'h1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    idle(8);
    issue(64'h9, 64'h4, 1'b0, 64'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    idle(8);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/csel_sub_64bit_pipe.md
# csel_sub_64bit_pipe

Four-stage pipelined 64-bit subtractor built from the same 4-bit carry-select blocks as the team's registered 64-bit carry-select adder. It is the subtract-direction counterpart to that adder. It computes op1 − op2 − bin over 16 bits per stage and passes the inter-stage carry through pipeline registers. It accepts one operation per cycle under a valid/ready handshake and delivers the difference, borrow-out and signed overflow four cycles later, in issue order.

## Interface

Parameters:
- (none): width is fixed at 64 bits, split into 4 stages × 16 bits, each stage made of four 4-bit select blocks.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- in_valid  in  1  op1/op2/bin are valid this cycle.
- in_ready  out  1  block can accept this cycle.
- op1  in  64  minuend (unsigned or two's complement).
- op2  in  64  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  diff/bout/ovf hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- diff  out  64  op1 − op2 − bin, mod 2^64.
- bout  out  1  unsigned borrow-out: 1 iff op1 < op2 + bin.
- ovf  out  1  signed overflow of the subtraction.

## Operation

- Arithmetic: op1 + ~op2 + ~bin. Carry into bit 0 is ~bin; bout = ~carry-out of bit 63.
- ovf = (op1[63] ≠ op2[63]) & (diff[63] ≠ op1[63]).
- Each 4-bit block computes sum/carry for carry-in 0 and carry-in 1 in parallel. The incoming carry muxes the pair.
- Stage k (k = 0..3) resolves bits [16k+15:16k]:
  - Stage 0 works combinationally on the accepted inputs.
  - Stages 1–3 work on the registered operand slices and the registered carry of the previous stage.
- Pipeline registers per stage:
  - valid bit.
  - the diff bits resolved so far.
  - the carry out of the stage.
  - the unconsumed upper slices of ~op2 and op1.
  - op1[63] and op2[63] for the ovf computation.
- Stage 3 registers drive diff, bout, ovf and out_valid directly, with no output combinational logic.
- Flow control is a global advance: adv = ~out_valid | out_ready.
  - in_ready = adv & reset.
  - When adv = 1, every stage shifts one position. A bubble enters when in_valid & in_ready is 0.
  - When adv = 0, every register holds, including diff/bout/ovf.
- Ordering: strictly FIFO. No result is dropped or duplicated.

## Timing

- Latency: an op accepted at edge E (in_valid & in_ready high in the cycle before E) appears with out_valid = 1 after edge E+3. That is, in_valid in cycle t gives out_valid in cycle t+4 when there is no stall.
- Throughput: 1 op per cycle while out_ready = 1.
- A stall cycle (out_valid & ~out_ready) adds exactly one cycle to every in-flight op. Outputs stay stable throughout the stall.
- Reset (reset = 0 at a rising edge):
  - All valid bits clear; diff = 0, bout = 0, ovf = 0, out_valid = 0.
  - in_ready = 0 combinationally while reset is low.
  - In-flight ops are discarded. The first acceptance is possible in the first cycle with reset = 1.
- Reset mid-stream: no partial or stale result ever appears after release.
- Simultaneous accept and consume in the same cycle is legal and sustains full rate.
- Input values with in_valid = 0 must not affect any output.

## Test plan

- Reset: hold reset = 0 for 2 cycles with in_valid = 1 → out_valid = 0, diff = 0, bout = 0, ovf = 0, in_ready = 0. After release, in_ready = 1 and nothing emerges.
- Basic: 0x5 − 0x3, bin = 0, in_valid in cycle t, out_ready = 1 → cycle t+4: diff = 0x2, bout = 0, ovf = 0, out_valid high for exactly one cycle.
- Full borrow ripple:
  - 0x0 − 0x1 → diff = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, ovf = 0.
  - 0x1_0000 − 0x0 with bin = 1 → diff = 0xFFFF, bout = 0 (borrow crosses the stage 0/1 boundary).
- Signed overflow:
  - 0x8000_0000_0000_0000 − 0x1 → diff = 0x7FFF_FFFF_FFFF_FFFF, bout = 0, ovf = 1.
  - 0x7FFF_FFFF_FFFF_FFFF − 0xFFFF_FFFF_FFFF_FFFF → diff = 0x8000_0000_0000_0000, bout = 1, ovf = 1.
- Backpressure: 6 back-to-back ops (i − 2i for i = 1..6) with out_ready pattern 1,0,0,1,0,1,1,… → 6 results in order, matching a reference model. Outputs are unchanged across every stall cycle, and in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-flight: issue 3 ops, then assert reset for 1 cycle 2 cycles later → out_valid stays 0 afterwards. A new op 0x9 − 0x4 issued after release yields only diff = 0x5, at +4 cycles.
